// File: rtl/voice_pkg.sv
// Shared definitions for the per-voice envelope stage.
//   env_state_e : state encoding driven onto env_state
//   ENV_MAX     : full-scale envelope level
//   SUS_SCALE   : sustain index to level multiplier (15 * 17 = 255)
//   period()    : ticks per level step for a rate index
package voice_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAttack  = 3'd1,
    StDecay   = 3'd2,
    StSustain = 3'd3,
    StRelease = 3'd4
  } env_state_e;

  localparam int unsigned ENV_MAX   = 255;
  localparam int unsigned SUS_SCALE = 17;

  function automatic int unsigned period(input int unsigned r);
    return 32'd1 << r;
  endfunction

endpackage

// File: rtl/voice_envelope_if.sv
// Control and data bundle between a voice's wave generator/controller and its
// envelope stage.
//   master : drives tick, gate, rates, sustain and wave_in; reads level/state/out
//   slave  : the envelope stage itself
// The release rate is named release_rate because release is a reserved word.
interface voice_envelope_if #(
  parameter int unsigned OUTPUT_BITS = 12,
  parameter int unsigned ENV_BITS    = 8,
  parameter int unsigned RATE_BITS   = 4
) ();

  logic                          tick;
  logic                          gate;
  logic        [RATE_BITS-1:0]   attack;
  logic        [RATE_BITS-1:0]   decay;
  logic        [RATE_BITS-1:0]   sustain;
  logic        [RATE_BITS-1:0]   release_rate;
  logic signed [OUTPUT_BITS-1:0] wave_in;
  logic        [ENV_BITS-1:0]    env_level;
  logic        [2:0]             env_state;
  logic signed [OUTPUT_BITS-1:0] out;

  modport master (
    output tick, gate, attack, decay, sustain, release_rate, wave_in,
    input  env_level, env_state, out
  );

  modport slave (
    input  tick, gate, attack, decay, sustain, release_rate, wave_in,
    output env_level, env_state, out
  );

endinterface

// File: rtl/envelope_prescaler.sv
// Rate prescaler for the envelope: counts ticks and emits a one-cycle step
// strobe every 2**rate ticks.
//   main_clk, reset : clock, synchronous active-high reset
//   tick            : advance strobe
//   clear           : force the count to zero; suppresses the step
//   rate            : live rate index, compared every tick
//   step            : combinational strobe, valid on the tick that completes a period
module envelope_prescaler
  import voice_pkg::*;
#(
  parameter int unsigned PRESCALE_BITS = 16,
  parameter int unsigned RATE_BITS     = 4
) (
  input  logic                 main_clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 clear,
  input  logic [RATE_BITS-1:0] rate,
  output logic                 step
);

  logic [PRESCALE_BITS-1:0] count_q, count_d;
  logic [PRESCALE_BITS:0]   count_inc;
  logic                     hit;

  assign count_inc = {1'b0, count_q} + (PRESCALE_BITS + 1)'(1);
  // Compare against the live rate so a lowered rate fires immediately.
  assign hit       = 32'(count_inc) >= period(32'(rate));
  assign step      = tick & ~clear & hit;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick) begin
      count_d = hit ? '0 : count_inc[PRESCALE_BITS-1:0];
    end
  end

  always_ff @(posedge main_clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/voice_envelope.sv
// ADSR envelope stage for one voice: tracks the gate, steps an envelope level
// through attack/decay/sustain/release and scales the incoming waveform by it.
//   main_clk, reset : clock, synchronous active-high reset
//   bus (slave)     : tick, gate, attack/decay/sustain/release_rate, wave_in in;
//                     env_level, env_state, out (all registered) out
module voice_envelope
  import voice_pkg::*;
#(
  parameter int unsigned OUTPUT_BITS   = 12,
  parameter int unsigned ENV_BITS      = 8,
  parameter int unsigned RATE_BITS     = 4,
  parameter int unsigned PRESCALE_BITS = 16
) (
  input  logic             main_clk,
  input  logic             reset,
  voice_envelope_if.slave  bus
);

  localparam int unsigned ProdBits = OUTPUT_BITS + ENV_BITS + 1;
  localparam logic [ENV_BITS-1:0] LevelMax = ENV_BITS'(ENV_MAX);

  logic                          gate_q;
  logic                          rise, fall;
  env_state_e                    state_q, state_d;
  logic        [ENV_BITS-1:0]    level_q, level_d;
  logic signed [OUTPUT_BITS-1:0] out_q, out_d;
  logic        [ENV_BITS-1:0]    sus_lvl;
  logic        [RATE_BITS-1:0]   rate;
  logic                          pre_clear, step;

  assign rise    = bus.gate & ~gate_q;
  assign fall    = ~bus.gate & gate_q;
  assign sus_lvl = ENV_BITS'(32'(bus.sustain) * SUS_SCALE);

  always_comb begin
    rate = bus.attack;
    case (state_q)
      StDecay:   rate = bus.decay;
      StRelease: rate = bus.release_rate;
      default:   rate = bus.attack;
    endcase
  end

  // Gate edges restart the period; IDLE and SUSTAIN keep the count parked at 0.
  assign pre_clear = rise | fall | (state_q == StIdle) | (state_q == StSustain);

  envelope_prescaler #(
    .PRESCALE_BITS(PRESCALE_BITS),
    .RATE_BITS    (RATE_BITS)
  ) u_prescaler (
    .main_clk(main_clk),
    .reset   (reset),
    .tick    (bus.tick),
    .clear   (pre_clear),
    .rate    (rate),
    .step    (step)
  );

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (rise) begin
      state_d = StAttack;
    end else if (fall) begin
      if (state_q inside {StAttack, StDecay, StSustain}) state_d = StRelease;
    end else begin
      case (state_q)
        StAttack: begin
          if (step) begin
            if (level_q != LevelMax) level_d = level_q + ENV_BITS'(1);
            if (level_d == LevelMax) state_d = StDecay;
          end
        end
        StDecay: begin
          if (step) begin
            // Sustain may have been raised above the level: settle without stepping.
            if (level_q <= sus_lvl) begin
              state_d = StSustain;
            end else begin
              level_d = level_q - ENV_BITS'(1);
              if (level_d <= sus_lvl) state_d = StSustain;
            end
          end
        end
        StSustain: begin
          if (bus.tick && (sus_lvl < level_q)) state_d = StDecay;
        end
        StRelease: begin
          if (step) begin
            if (level_q != '0) level_d = level_q - ENV_BITS'(1);
            if (level_d == '0) state_d = StIdle;
          end
        end
        default: ;
      endcase
    end
  end

  // Level is treated as unsigned; 12x9 signed product fits in 20 bits.
  logic signed [ProdBits-1:0] wave_ext, level_ext, prod;
  logic                       unused_prod;

  assign wave_ext    = ProdBits'(bus.wave_in);
  assign level_ext   = ProdBits'({1'b0, level_q});
  assign prod        = wave_ext * level_ext;
  assign out_d       = prod[OUTPUT_BITS+ENV_BITS-1 -: OUTPUT_BITS];
  assign unused_prod = ^{prod[ProdBits-1], prod[ENV_BITS-1:0]};

  always_ff @(posedge main_clk) begin
    if (reset) begin
      gate_q  <= 1'b0;
      state_q <= StIdle;
      level_q <= '0;
      out_q   <= '0;
    end else begin
      gate_q  <= bus.gate;
      state_q <= state_d;
      level_q <= level_d;
      out_q   <= out_d;
    end
  end

  assign bus.env_level = level_q;
  assign bus.env_state = state_q;
  assign bus.out       = out_q;

endmodule

// File: tb/tb_voice_envelope.sv
// Bench for voice_envelope: directed phase table with hand-derived expectations,
// then randomized stimulus, with every cycle compared against a behavioural model.
module tb_voice_envelope;

  logic main_clk = 1'b0;
  logic reset;

  voice_envelope_if vif ();

  voice_envelope dut (
    .main_clk(main_clk),
    .reset   (reset),
    .bus     (vif.slave)
  );

  always #5 main_clk = ~main_clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: plain integers, state numbers as listed in the state table.
  int m_state = 0;
  int m_level = 0;
  int m_out   = 0;
  int m_ticks = 0;   // ticks counted since the last level step
  bit m_gprev = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d, wanted %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Apply the current inputs for one clock, advance the model, compare.
  task automatic run_cycle();
    int w, lvl, st, cnt, per, sus, nout;
    bit g, rise, fall, fire;
    w    = vif.wave_in;
    g    = vif.gate;
    lvl  = m_level;
    st   = m_state;
    cnt  = m_ticks;
    nout = (w * m_level) >>> 8;
    rise = g && !m_gprev;
    fall = !g && m_gprev;
    fire = 1'b0;
    sus  = int'(vif.sustain) * 17;
    per  = 1;
    if (st == 1) per = 1 << vif.attack;
    if (st == 2) per = 1 << vif.decay;
    if (st == 4) per = 1 << vif.release_rate;
    if (reset) begin
      st = 0; lvl = 0; cnt = 0; nout = 0; g = 1'b0;
    end else if (rise) begin
      st = 1; cnt = 0;
    end else if (fall) begin
      cnt = 0;
      if (st >= 1 && st <= 3) st = 4;
    end else if (vif.tick) begin
      if (st == 3) begin
        if (lvl > sus) st = 2;
      end else if (st != 0) begin
        cnt++;
        if (cnt >= per) begin
          cnt  = 0;
          fire = 1'b1;
        end
      end
    end
    if (fire) begin
      if (st == 1) begin
        lvl = (lvl < 255) ? lvl + 1 : 255;
        if (lvl == 255) st = 2;
      end else if (st == 2) begin
        if (lvl <= sus) st = 3;
        else begin
          lvl--;
          if (lvl <= sus) st = 3;
        end
      end else if (st == 4) begin
        lvl = (lvl > 0) ? lvl - 1 : 0;
        if (lvl == 0) st = 0;
      end
    end
    @(posedge main_clk);
    #1;
    m_state = st;
    m_level = lvl;
    m_ticks = cnt;
    m_out   = nout;
    m_gprev = g;
    check("model_level", int'(vif.env_level), m_level);
    check("model_state", int'(vif.env_state), m_state);
    check("model_out", int'(vif.out), m_out);
  endtask

  typedef struct {
    int n;
    bit gate;
    bit tick;
    int attack;
    int decay;
    int sustain;
    int rel;
    int wave;
    int exp_level;
    int exp_state;
    bit chk_out;
    int exp_out;
  } vec_t;

  vec_t vecs[31];

  initial begin
    // n  gate tick  a  d   s  r  wave   level state chk out
    vecs[0]  = '{1,   1, 1, 0, 0, 8,  0, 1000,  0,   1, 0, 0};     // first rise after reset
    vecs[1]  = '{255, 1, 1, 0, 0, 8,  0, 1000,  255, 2, 0, 0};     // fast attack tops out
    vecs[2]  = '{119, 1, 1, 0, 0, 8,  0, 1000,  136, 3, 0, 0};     // decay to sustain 8*17
    vecs[3]  = '{20,  1, 1, 0, 0, 8,  0, 1000,  136, 3, 0, 0};     // sustain holds
    vecs[4]  = '{1,   0, 1, 0, 0, 8,  0, 1000,  136, 4, 0, 0};     // fall, no step
    vecs[5]  = '{136, 0, 1, 0, 0, 8,  0, 1000,  0,   0, 0, 0};     // release to idle
    vecs[6]  = '{1,   1, 1, 3, 0, 8,  0, 1500,  0,   1, 1, 0};     // level 0 gives out 0
    vecs[7]  = '{80,  1, 1, 3, 0, 8,  0, 1000,  10,  1, 0, 0};     // one step per 8 ticks
    vecs[8]  = '{50,  1, 0, 3, 0, 8,  0, 1000,  10,  1, 0, 0};     // no tick, no step
    vecs[9]  = '{7,   1, 1, 3, 0, 8,  0, 1000,  10,  1, 0, 0};
    vecs[10] = '{1,   1, 1, 3, 0, 8,  0, 1000,  11,  1, 0, 0};     // 8th tick steps
    vecs[11] = '{89,  1, 1, 0, 0, 8,  0, 1000,  100, 1, 0, 0};
    vecs[12] = '{1,   0, 1, 0, 0, 8,  1, 1000,  100, 4, 0, 0};     // release mid-attack
    vecs[13] = '{100, 0, 1, 0, 0, 8,  1, 1000,  50,  4, 0, 0};
    vecs[14] = '{1,   1, 1, 0, 0, 8,  1, 1000,  50,  1, 0, 0};     // re-rise keeps level
    vecs[15] = '{5,   1, 1, 0, 0, 8,  1, 1000,  55,  1, 0, 0};
    vecs[16] = '{1,   0, 1, 0, 0, 8,  1, 1000,  55,  4, 0, 0};
    vecs[17] = '{110, 0, 1, 0, 0, 8,  1, 1000,  0,   0, 0, 0};
    vecs[18] = '{1,   1, 1, 1, 0, 8,  1, 1000,  0,   1, 0, 0};
    vecs[19] = '{3,   1, 1, 1, 0, 8,  1, 1000,  1,   1, 0, 0};     // next tick would step
    vecs[20] = '{1,   0, 1, 1, 0, 8,  1, 1000,  1,   4, 0, 0};     // fall beats the step
    vecs[21] = '{1,   0, 1, 1, 0, 8,  1, 1000,  1,   4, 0, 0};     // count restarted
    vecs[22] = '{1,   0, 1, 1, 0, 8,  1, 1000,  0,   0, 0, 0};
    vecs[23] = '{1,   1, 1, 0, 0, 15, 0, 1000,  0,   1, 0, 0};
    vecs[24] = '{255, 1, 1, 0, 0, 15, 0, 1000,  255, 2, 0, 0};
    vecs[25] = '{1,   1, 1, 0, 0, 15, 0, 1000,  255, 3, 0, 0};     // already at sustain
    vecs[26] = '{1,   1, 0, 0, 0, 0,  0, -2048, 255, 3, 1, -2040}; // full-scale scaling
    vecs[27] = '{1,   1, 1, 0, 0, 0,  0, 1000,  255, 2, 0, 0};     // lowered sustain
    vecs[28] = '{1,   1, 1, 0, 0, 0,  0, 1000,  254, 2, 0, 0};
    vecs[29] = '{126, 1, 1, 0, 0, 0,  0, 2047,  128, 2, 0, 0};
    vecs[30] = '{1,   1, 0, 0, 0, 0,  0, 2047,  128, 2, 1, 1023};  // half-scale scaling

    reset            = 1'b1;
    vif.gate         = 1'b1;
    vif.tick         = 1'b1;
    vif.attack       = '0;
    vif.decay        = '0;
    vif.sustain      = 4'd8;
    vif.release_rate = '0;
    vif.wave_in      = 12'sd1000;

    // Reset held with gate and tick high: nothing may move.
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      check("reset_level", int'(vif.env_level), 0);
      check("reset_state", int'(vif.env_state), 0);
      check("reset_out", int'(vif.out), 0);
    end
    reset = 1'b0;

    for (int v = 0; v < 31; v++) begin
      vif.gate         = vecs[v].gate;
      vif.tick         = vecs[v].tick;
      vif.attack       = 4'(vecs[v].attack);
      vif.decay        = 4'(vecs[v].decay);
      vif.sustain      = 4'(vecs[v].sustain);
      vif.release_rate = 4'(vecs[v].rel);
      vif.wave_in      = 12'(vecs[v].wave);
      for (int c = 0; c < vecs[v].n; c++) run_cycle();
      check($sformatf("vec%0d_level", v), int'(vif.env_level), vecs[v].exp_level);
      check($sformatf("vec%0d_state", v), int'(vif.env_state), vecs[v].exp_state);
      if (vecs[v].chk_out) check($sformatf("vec%0d_out", v), int'(vif.out), vecs[v].exp_out);
    end

    // Randomized run: slow gate, small rates so levels travel far.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        vif.attack       = 4'($urandom_range(0, 3));
        vif.decay        = 4'($urandom_range(0, 3));
        vif.release_rate = 4'($urandom_range(0, 3));
        vif.sustain      = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 299) == 0) vif.gate = ~vif.gate;
      vif.tick    = 1'($urandom_range(0, 1));
      vif.wave_in = 12'($urandom);
      reset       = ($urandom_range(0, 999) == 0);
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
